// File: rtl/mem_port_arbiter.sv
// Single-port core RAM arbiter: instruction fetch vs. ALU load/store, with fetch starvation
// limit, store byte-lane generation, load alignment/extension and fixed-latency responses.
package mem_port_arbiter_pkg;
  localparam int cXLEN       = 32;
  localparam int cRegSelBitW = 5;
  localparam int cRamDepth   = 1024;

  // opType uses the RISC-V funct3 encoding for loads and stores
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef struct packed {
    logic                   read;
    logic                   write;
    logic [cXLEN-1:0]       addr;
    logic [cXLEN-1:0]       data;
    logic [2:0]             opType;
    logic [cRegSelBitW-1:0] rdAddr;
  } tMemOp;
endpackage

// Handshake: a requester holds its request until the same-cycle grant; every response is a
// single-cycle valid pulse with no back-pressure.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int cStarveLimit = 4,
  parameter int cAddrW       = $clog2(cRamDepth)
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iFetchReq,
  input  logic [cXLEN-1:0]       iFetchAddr,
  input  logic                   iFlush,
  output logic                   oFetchGnt,
  output logic                   oFetchRvalid,
  output logic [cXLEN-1:0]       oFetchRdata,
  input  tMemOp                  iMemOp,
  output logic                   oMemGnt,
  output logic                   oMemRvalid,
  output logic [cXLEN-1:0]       oMemRdata,
  output logic [cRegSelBitW-1:0] oMemRdAddr,
  output logic                   oMisalign,
  output logic                   oRamEn,
  output logic                   oRamWe,
  output logic [cAddrW-1:0]      oRamAddr,
  output logic [3:0]             oRamBe,
  output logic [cXLEN-1:0]       oRamWdata,
  input  logic [cXLEN-1:0]       iRamRdata
);
  localparam logic [3:0] cLimit = 4'(cStarveLimit);

  logic [3:0]             starve_cnt_q, starve_cnt_d;
  logic                   fetch_pend_q, fetch_pend_d;
  logic                   load_pend_q, load_pend_d;
  logic [2:0]             ld_type_q, ld_type_d;
  logic [1:0]             ld_off_q, ld_off_d;
  logic [cRegSelBitW-1:0] ld_rd_q, ld_rd_d;
  logic                   misalign_q, misalign_d;
  logic                   fetch_rvalid_q, fetch_rvalid_d;
  logic [cXLEN-1:0]       fetch_rdata_q, fetch_rdata_d;
  logic                   mem_rvalid_q, mem_rvalid_d;
  logic [cXLEN-1:0]       mem_rdata_q, mem_rdata_d;
  logic [cRegSelBitW-1:0] mem_rd_addr_q, mem_rd_addr_d;

  logic             mem_req, is_write, misalign, fetch_win, mem_gnt, mem_ram;
  logic [1:0]       off;
  logic [cXLEN-1:0] shifted, load_ext;
  logic [15:0]      half;
  logic             unused_bits;

  assign unused_bits = ^{iFetchAddr[cXLEN-1:cAddrW+2], iFetchAddr[1:0],
                         iMemOp.addr[cXLEN-1:cAddrW+2]};

  always_comb begin
    mem_req  = iMemOp.read | iMemOp.write;
    is_write = iMemOp.write;
    off      = iMemOp.addr[1:0];
    case (iMemOp.opType[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = off[0];
      default: misalign = |off;
    endcase

    fetch_win = !iRst && iFetchReq && !iFlush && (!mem_req || starve_cnt_q == cLimit);
    mem_gnt   = !iRst && mem_req && !fetch_win;
    mem_ram   = mem_gnt && !misalign;

    starve_cnt_d = starve_cnt_q;
    if (!iFetchReq || fetch_win)
      starve_cnt_d = '0;
    else if (mem_gnt && starve_cnt_q != cLimit)
      starve_cnt_d = starve_cnt_q + 4'd1;

    oFetchGnt = fetch_win;
    oMemGnt   = mem_gnt;
    oRamEn    = fetch_win | mem_ram;
    oRamWe    = mem_ram & is_write;
    oRamAddr  = fetch_win ? iFetchAddr[cAddrW+1:2] : iMemOp.addr[cAddrW+1:2];
    oRamBe    = 4'b0000;
    oRamWdata = '0;
    if (mem_ram && is_write) begin
      case (iMemOp.opType[1:0])
        2'b00: begin
          oRamBe    = 4'b0001 << off;
          oRamWdata = {4{iMemOp.data[7:0]}};
        end
        2'b01: begin
          oRamBe    = 4'b0011 << off;
          oRamWdata = {2{iMemOp.data[15:0]}};
        end
        default: begin
          oRamBe    = 4'b1111;
          oRamWdata = iMemOp.data;
        end
      endcase
    end

    // Tag stage: what was granted last cycle, aligned with iRamRdata
    fetch_pend_d = fetch_win;
    load_pend_d  = mem_ram && !is_write;
    ld_type_d    = iMemOp.opType;
    ld_off_d     = off;
    ld_rd_d      = iMemOp.rdAddr;
    misalign_d   = mem_gnt && misalign;

    shifted = iRamRdata >> {ld_off_q, 3'b000};
    half    = ld_off_q[1] ? iRamRdata[31:16] : iRamRdata[15:0];
    case (ld_type_q)
      OP_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      OP_BU:   load_ext = {24'd0, shifted[7:0]};
      OP_H:    load_ext = {{16{half[15]}}, half};
      OP_HU:   load_ext = {16'd0, half};
      default: load_ext = iRamRdata;
    endcase

    fetch_rvalid_d = fetch_pend_q && !iFlush;
    fetch_rdata_d  = fetch_pend_q ? iRamRdata : fetch_rdata_q;
    mem_rvalid_d   = load_pend_q;
    mem_rdata_d    = load_pend_q ? load_ext : mem_rdata_q;
    mem_rd_addr_d  = load_pend_q ? ld_rd_q : mem_rd_addr_q;
  end

  // A flush in the response cycle itself still kills the registered fetch response
  assign oFetchRvalid = fetch_rvalid_q && !iFlush;
  assign oFetchRdata  = fetch_rdata_q;
  assign oMemRvalid   = mem_rvalid_q;
  assign oMemRdata    = mem_rdata_q;
  assign oMemRdAddr   = mem_rd_addr_q;
  assign oMisalign    = misalign_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      starve_cnt_q   <= '0;
      fetch_pend_q   <= 1'b0;
      load_pend_q    <= 1'b0;
      ld_type_q      <= '0;
      ld_off_q       <= '0;
      ld_rd_q        <= '0;
      misalign_q     <= 1'b0;
      fetch_rvalid_q <= 1'b0;
      fetch_rdata_q  <= '0;
      mem_rvalid_q   <= 1'b0;
      mem_rdata_q    <= '0;
      mem_rd_addr_q  <= '0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      fetch_pend_q   <= fetch_pend_d;
      load_pend_q    <= load_pend_d;
      ld_type_q      <= ld_type_d;
      ld_off_q       <= ld_off_d;
      ld_rd_q        <= ld_rd_d;
      misalign_q     <= misalign_d;
      fetch_rvalid_q <= fetch_rvalid_d;
      fetch_rdata_q  <= fetch_rdata_d;
      mem_rvalid_q   <= mem_rvalid_d;
      mem_rdata_q    <= mem_rdata_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
    end
  end
endmodule
